// File: rtl/keypad_matrix_scanner.sv
// Matrix keypad scanner: column scan, single-key debounce and a key-event FIFO
// with a valid/ready handoff. Event payload is the linear key index row*COLS+col.
// Optional build macro KEYPAD_RELEASE_EVT_EN: release events are also queued and
// the FIFO word carries a release flag; otherwise key_release is tied low.
module keypad_matrix_scanner #(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned SCAN_DIV   = 131072,
    parameter int unsigned DEBOUNCE   = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ROWS-1:0]                 row,
    output logic [COLS-1:0]                 col,
    output logic                            key_valid,
    input  logic                            key_ready,
    output logic [$clog2(ROWS*COLS)-1:0]    key_code,
    output logic                            key_release,
    output logic                            key_down,
    output logic                            overflow,
    input  logic                            ovf_clr
);

    localparam int unsigned CW   = $clog2(ROWS*COLS);
    localparam int unsigned RW   = $clog2(ROWS);
    localparam int unsigned KW   = $clog2(COLS);
    localparam int unsigned DW   = $clog2(SCAN_DIV);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned NW   = AW + 1;
    localparam int unsigned CNTW = 4;
`ifdef KEYPAD_RELEASE_EVT_EN
    localparam int unsigned FW   = CW + 1;
`else
    localparam int unsigned FW   = CW;
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCAN     = 3'd1,
        PRESS_DB = 3'd2,
        HELD     = 3'd3,
        REL_DB   = 3'd4
    } state_t;

    state_t            state, state_next;
    logic [ROWS-1:0]   row_meta, row_sync;
    logic [DW-1:0]     div;
    logic              tick;
    logic [KW-1:0]     k, k_next;
    logic [RW-1:0]     r, r_next;
    logic [KW-1:0]     c, c_next;
    logic [CNTW-1:0]   cnt, cnt_next;
    logic [COLS-1:0]   col_next;
    logic              key_down_next;
    logic              all_high;
    logic [RW-1:0]     low_row;
    logic              row_r;
    logic              push;
    logic [CW-1:0]     push_code;
`ifdef KEYPAD_RELEASE_EVT_EN
    logic              push_rel;
`endif
    logic [FW-1:0]     push_word;

    logic [FW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr, wr_next, rd_next;
    logic [NW-1:0]     count, count_next;
    logic [FW-1:0]     head, head_next;
    logic              pop, full, push_acc, drop;

    function automatic logic [CW-1:0] key_index(input logic [RW-1:0] ri, input logic [KW-1:0] ci);
        return CW'(32'(ri) * COLS + 32'(ci));
    endfunction

    // Two-flop synchronizer for the asynchronous row pins (idle level is high)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Scan-rate divider; tick is high for the last count of each period
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div <= '0;
        else if (tick) div <= '0;
        else           div <= div + DW'(1);
    end

    assign tick = (div == DW'(SCAN_DIV - 1));

    // Row decode: all-high detect, lowest pressed row and the tracked row level
    always_comb begin
        all_high = &row_sync;
        low_row  = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!row_sync[i]) low_row = RW'(i);
        end
        row_r = row_sync[r];
    end

    // FSM state and scan datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            r        <= '0;
            c        <= '0;
            cnt      <= '0;
            col      <= '0;
            key_down <= 1'b0;
        end else begin
            state    <= state_next;
            k        <= k_next;
            r        <= r_next;
            c        <= c_next;
            cnt      <= cnt_next;
            col      <= col_next;
            key_down <= key_down_next;
        end
    end

    // Next-state, column drive and event generation; only moves on a tick
    always_comb begin
        state_next = state;
        k_next     = k;
        r_next     = r;
        c_next     = c;
        cnt_next   = cnt;
        col_next   = col;
        push       = 1'b0;
        push_code  = key_index(r, c);
`ifdef KEYPAD_RELEASE_EVT_EN
        push_rel   = 1'b0;
`endif
        if (tick) begin
            case (state)
                IDLE: begin
                    col_next = '0;
                    if (!all_high) begin
                        state_next = SCAN;
                        k_next     = '0;
                        col_next   = ~COLS'(1);
                    end
                end
                SCAN: begin
                    if (!all_high) begin
                        r_next   = low_row;
                        c_next   = k;
                        cnt_next = CNTW'(1);
                        col_next = ~(COLS'(1) << k);
                        if (DEBOUNCE == 1) begin
                            push       = 1'b1;
                            push_code  = key_index(low_row, k);
                            state_next = HELD;
                        end else begin
                            state_next = PRESS_DB;
                        end
                    end else if (k == KW'(COLS - 1)) begin
                        state_next = IDLE;
                        col_next   = '0;
                    end else begin
                        k_next   = k + KW'(1);
                        col_next = ~(COLS'(1) << k_next);
                    end
                end
                PRESS_DB: begin
                    if (!row_r) begin
                        cnt_next = cnt + CNTW'(1);
                        if (cnt + CNTW'(1) == CNTW'(DEBOUNCE)) begin
                            push       = 1'b1;
                            state_next = HELD;
                        end
                    end else begin
                        state_next = IDLE;
                        col_next   = '0;
                    end
                end
                HELD: begin
                    if (row_r) begin
                        cnt_next = CNTW'(1);
                        if (DEBOUNCE == 1) begin
`ifdef KEYPAD_RELEASE_EVT_EN
                            push     = 1'b1;
                            push_rel = 1'b1;
`endif
                            state_next = IDLE;
                            col_next   = '0;
                        end else begin
                            state_next = REL_DB;
                        end
                    end
                end
                REL_DB: begin
                    if (row_r) begin
                        cnt_next = cnt + CNTW'(1);
                        if (cnt + CNTW'(1) == CNTW'(DEBOUNCE)) begin
`ifdef KEYPAD_RELEASE_EVT_EN
                            push     = 1'b1;
                            push_rel = 1'b1;
`endif
                            state_next = IDLE;
                            col_next   = '0;
                        end
                    end else begin
                        state_next = HELD;
                    end
                end
                default: begin
                    state_next = IDLE;
                    col_next   = '0;
                end
            endcase
        end
        key_down_next = (state_next == HELD) || (state_next == REL_DB);
    end

`ifdef KEYPAD_RELEASE_EVT_EN
    assign push_word   = {push_rel, push_code};
    assign key_release = head[CW];
`else
    assign push_word   = push_code;
    assign key_release = 1'b0;
`endif
    assign key_code = head[CW-1:0];

    // FIFO control: simultaneous push and pop on a full FIFO loses nothing
    always_comb begin
        pop        = key_valid && key_ready;
        full       = (count == NW'(FIFO_DEPTH));
        push_acc   = push && (!full || pop);
        drop       = push && full && !pop;
        wr_next    = push_acc ? wr_ptr + AW'(1) : wr_ptr;
        rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_next = count + NW'(push_acc) - NW'(pop);
        head_next  = head;
        if (count_next != '0) begin
            head_next = (push_acc && (wr_ptr == rd_next)) ? push_word : mem[rd_next];
        end
    end

    // FIFO storage (no reset needed; contents qualified by count)
    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr] <= push_word;
    end

    // FIFO pointers, registered head outputs and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            key_valid <= 1'b0;
            head      <= '0;
            overflow  <= 1'b0;
        end else begin
            wr_ptr    <= wr_next;
            rd_ptr    <= rd_next;
            count     <= count_next;
            key_valid <= (count_next != '0);
            head      <= head_next;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner: a keypad model drives the rows,
// expected events come from timing rules on hold duration, a monitor checks pops.
module tb_keypad_matrix_scanner;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int SDIV  = 4;
    localparam int DEB   = 3;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int GAP   = 10;

    typedef struct packed {
        logic          rel;
        logic [CW-1:0] code;
    } ev_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [ROWS-1:0]        row;
    logic [COLS-1:0]        col;
    logic                   key_valid;
    logic                   key_ready;
    logic [CW-1:0]          key_code;
    logic                   key_release;
    logic                   key_down;
    logic                   overflow;
    logic                   ovf_clr;

    logic [ROWS*COLS-1:0]   keys;
    int                     cyc;
    int                     checks = 0;
    int                     errors = 0;
    int                     ready_mode;
    bit                     ovf_model;
    ev_t                    exp_q[$];

    keypad_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .row(row), .col(col),
        .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
        .key_release(key_release), .key_down(key_down),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Clock count since reset release; tick edges fall where cyc % SDIV == 0
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Keypad: a row reads low when a pressed key sits on a driven-low column
    always_comb begin
        for (int ri = 0; ri < ROWS; ri++) begin
            row[ri] = 1'b1;
            for (int ci = 0; ci < COLS; ci++) begin
                if (keys[ri*COLS+ci] && !col[ci]) row[ri] = 1'b0;
            end
        end
    end

    // Consumer ready: 0 = never, 1 = random, 2 = always, 3 = driven by the test
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: key_ready = 1'b0;
            1: key_ready = 1'($urandom_range(0, 1));
            2: key_ready = 1'b1;
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every accepted handshake must match the oldest expected event
    always @(negedge clk) begin
        if (!rst && key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got code %0d rel %0d expected none", key_code, key_release);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("event_code", 32'(key_code), 32'(e.code));
                check("event_release", 32'(key_release), 32'(e.rel));
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do begin
                @(posedge clk);
                #1;
            end while (cyc % SDIV != 0);
        end
    endtask

    function automatic int win_col(input logic [ROWS*COLS-1:0] set);
        for (int ci = 0; ci < COLS; ci++)
            for (int ri = 0; ri < ROWS; ri++)
                if (set[ri*COLS+ci]) return ci;
        return 0;
    endfunction

    function automatic int win_code(input logic [ROWS*COLS-1:0] set);
        for (int ci = 0; ci < COLS; ci++)
            for (int ri = 0; ri < ROWS; ri++)
                if (set[ri*COLS+ci]) return ri*COLS + ci;
        return 0;
    endfunction

    // Queue an expected event unless the model FIFO is already full
    task automatic push_exp(input logic rel, input int code, input bit force_accept);
        if (!force_accept && exp_q.size() >= DEPTH) ovf_model = 1'b1;
        else exp_q.push_back({rel, CW'(code)});
    endtask

    // Hold a key set for n ticks from idle: press accepted once the scan reaches
    // the winning column and DEBOUNCE samples have been seen
    task automatic do_press(input logic [ROWS*COLS-1:0] set, input int n, input bit force_accept);
        int  code;
        bit  hit;
        code = win_code(set);
        hit  = (n >= win_col(set) + DEB + 1);
        if (hit) push_exp(1'b0, code, force_accept);
        keys = set;
        wait_ticks(n);
        keys = '0;
`ifdef KEYPAD_RELEASE_EVT_EN
        if (hit) push_exp(1'b1, code, 1'b0);
`endif
        wait_ticks(GAP);
    endtask

    task automatic pulse_ovf_clr();
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr   = 1'b0;
        ovf_model = 1'b0;
    endtask

    task automatic drain(input string name);
        ready_mode = 1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [ROWS*COLS-1:0] set;
        rst        = 1'b1;
        keys       = '0;
        ovf_clr    = 1'b0;
        key_ready  = 1'b0;
        ready_mode = 0;
        ovf_model  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col", 32'(col), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_release", 32'(key_release), 32'h0);
        check("rst_down", 32'(key_down), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_ticks(1);

        // r2c1 held 10 ticks with the consumer stalled
        push_exp(1'b0, 9, 1'b0);
        keys = '0;
        keys[9] = 1'b1;
        wait_ticks(4);
        check("t1_valid_before", 32'(key_valid), 32'h0);
        check("t1_down_before", 32'(key_down), 32'h0);
        wait_ticks(1);
        check("t1_valid", 32'(key_valid), 32'h1);
        check("t1_down", 32'(key_down), 32'h1);
        check("t1_code", 32'(key_code), 32'd9);
        check("t1_release", 32'(key_release), 32'h0);
        check("t1_col_held", 32'(col), 32'hD);
        wait_ticks(5);
        keys = '0;
`ifdef KEYPAD_RELEASE_EVT_EN
        push_exp(1'b1, 9, 1'b0);
`endif
        check("t1_valid_kept", 32'(key_valid), 32'h1);
        wait_ticks(2);
        check("t1_down_rel_db", 32'(key_down), 32'h1);
        wait_ticks(1);
        check("t1_down_released", 32'(key_down), 32'h0);
        check("t1_col_idle", 32'(col), 32'h0);
        drain("t1_drain");

        // Row glitch while in press debounce
        wait_ticks(1);
        keys = '0;
        keys[9] = 1'b1;
        wait_ticks(4);
        check("glitch_col_db", 32'(col), 32'hD);
        keys = '0;
        wait_ticks(1);
        check("glitch_col_idle", 32'(col), 32'h0);
        check("glitch_down", 32'(key_down), 32'h0);
        wait_ticks(GAP);

        // Five presses into a stalled FIFO
        ready_mode = 0;
        wait_ticks(1);
        foreach (exp_q[i]) ;
        begin
            int codes[5];
            codes = '{0, 5, 10, 15, 1};
            for (int i = 0; i < 5; i++) begin
                set = '0;
                set[codes[i]] = 1'b1;
                do_press(set, 8, 1'b0);
            end
        end
        check("ovf_set", 32'(overflow), 32'(ovf_model));
        check("ovf_valid", 32'(key_valid), 32'h1);
        check("ovf_head", 32'(key_code), 32'(exp_q[0].code));
        pulse_ovf_clr();
        check("ovf_clr", 32'(overflow), 32'h0);

        // Full FIFO: next press coincides with a single ready pulse
        ready_mode = 3;
        key_ready  = 1'b0;
        wait_ticks(1);
        set = '0;
        set[4] = 1'b1;
        fork
            do_press(set, DEB + 2, 1'b1);
            begin
                repeat (SDIV * (DEB + 1) - 1) @(posedge clk);
                #1 key_ready = 1'b1;
                @(posedge clk);
                #1 key_ready = 1'b0;
            end
        join
        check("fullpop_ovf", 32'(overflow), 32'(ovf_model));
        drain("fullpop_drain");
        pulse_ovf_clr();

        // Two keys at once: lowest column wins
        ready_mode = 1;
        wait_ticks(1);
        set = '0;
        set[6]  = 1'b1;
        set[12] = 1'b1;
        do_press(set, 10, 1'b0);
        drain("multi_drain");

        // Reset while in press debounce
        wait_ticks(1);
        keys = '0;
        keys[3] = 1'b1;
        wait_ticks(6);
        check("rstmid_col_db", 32'(col), 32'h7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_col", 32'(col), 32'h0);
        check("rstmid_valid", 32'(key_valid), 32'h0);
        check("rstmid_down", 32'(key_down), 32'h0);
        check("rstmid_ovf", 32'(overflow), 32'h0);
        check("rstmid_code", 32'(key_code), 32'h0);
        keys = '0;
        @(negedge clk);
        rst = 1'b0;
        wait_ticks(GAP);
        check("rstmid_no_event", 32'(key_valid), 32'h0);

        // Randomized key sets and hold durations
        for (int it = 0; it < 16; it++) begin
            set = '0;
            set[$urandom_range(0, ROWS*COLS-1)] = 1'b1;
            if ($urandom_range(0, 2) == 0) set[$urandom_range(0, ROWS*COLS-1)] = 1'b1;
            do_press(set, $urandom_range(1, 12), 1'b0);
        end
        drain("final_drain");
        check("final_ovf", 32'(overflow), 32'(ovf_model));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
